packetizer: RTL and testbench

Transmit-side counterpart of the stream parser. Accepts one message of up to 37 payload bytes per handshake, assigns the next per-stream sequence number (32 streams), and serializes the packet onto a 32-bit word stream: header word, sequence word, then payload words. The last word is flagged. This is the exact wire format the parser consumes, so a packetizer-to-parser loopback reports no packet loss.

---
 rtl/packetizer.sv | 142 ++++++++++++++
 tb/tb_packetizer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/packetizer.sv
// Packetizer: serializes one message (1..37 bytes) into header, sequence and
// payload words on a 32-bit stream, assigning per-stream sequence numbers.
module packetizer (
    input  logic           clk,
    input  logic           reset_b,
    input  logic [0:295]   msgIn,
    input  logic [5:0]     msgIn_len,
    input  logic [4:0]     msgIn_stream,
    input  logic           msgIn_val,
    output logic           msgIn_ready,
    output logic [31:0]    dataOut,
    output logic           dataOut_val,
    input  logic           dataOut_ready,
    output logic           dataOut_last,
    output logic           badLen
);

    typedef enum logic [1:0] {IDLE, HDR, SEQ, DATA} state_t;

    state_t        state_q, state_d;
    logic [0:319]  msg_q, msg_d;
    logic [31:0]   seq_q, seq_d;
    logic [3:0]    widx_q, widx_d;
    logic [3:0]    lastw_q, lastw_d;
    logic [31:0]   word_q, word_d;
    logic          val_q, val_d;
    logic          last_q, last_d;
    logic          rdy_q, rdy_d;
    logic          bad_q, bad_d;
    logic [31:0]   seqs_q [32];
    logic          seq_inc;
    logic          accept, len_ok, xfer;
    logic [15:0]   tot;

    assign msgIn_ready  = rdy_q;
    assign dataOut      = word_q;
    assign dataOut_val  = val_q;
    assign dataOut_last = last_q;
    assign badLen       = bad_q;

    always_comb begin
        accept  = msgIn_val & rdy_q;
        len_ok  = (msgIn_len != 6'd0) && (msgIn_len <= 6'd37);
        xfer    = val_q & dataOut_ready;
        tot     = 16'(msgIn_len) + 16'd8;
        state_d = state_q;
        msg_d   = msg_q;
        seq_d   = seq_q;
        widx_d  = widx_q;
        lastw_d = lastw_q;
        word_d  = word_q;
        val_d   = val_q;
        last_d  = last_q;
        rdy_d   = rdy_q;
        bad_d   = 1'b0;
        seq_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!len_ok) begin
                        bad_d = 1'b1;
                    end else begin
                        seq_inc = 1'b1;
                        // Bytes past L are zeroed at capture so payload words need no masking.
                        msg_d = '0;
                        for (int unsigned k = 0; k < 37; k++) begin
                            if (k < 32'(msgIn_len))
                                msg_d[8*k +: 8] = msgIn[8*k +: 8];
                        end
                        seq_d   = seqs_q[msgIn_stream];
                        lastw_d = 4'((msgIn_len - 6'd1) >> 2);
                        word_d  = {tot[7:0], tot[15:8], 8'h00, 3'b000, msgIn_stream};
                        val_d   = 1'b1;
                        rdy_d   = 1'b0;
                        state_d = HDR;
                    end
                end
            end
            HDR: begin
                if (xfer) begin
                    word_d  = {seq_q[7:0], seq_q[15:8], seq_q[23:16], seq_q[31:24]};
                    state_d = SEQ;
                end
            end
            SEQ: begin
                if (xfer) begin
                    word_d  = msg_q[0 +: 32];
                    last_d  = (lastw_q == 4'd0);
                    widx_d  = 4'd1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (xfer) begin
                    if (last_q) begin
                        word_d  = '0;
                        val_d   = 1'b0;
                        last_d  = 1'b0;
                        rdy_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        word_d = msg_q[{widx_q, 5'd0} +: 32];
                        last_d = (widx_q == lastw_q);
                        widx_d = widx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_q <= IDLE;
            msg_q   <= '0;
            seq_q   <= '0;
            widx_q  <= '0;
            lastw_q <= '0;
            word_q  <= '0;
            val_q   <= 1'b0;
            last_q  <= 1'b0;
            rdy_q   <= 1'b1;
            bad_q   <= 1'b0;
            for (int unsigned i = 0; i < 32; i++)
                seqs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            seq_q   <= seq_d;
            widx_q  <= widx_d;
            lastw_q <= lastw_d;
            word_q  <= word_d;
            val_q   <= val_d;
            last_q  <= last_d;
            rdy_q   <= rdy_d;
            bad_q   <= bad_d;
            if (seq_inc)
                seqs_q[msgIn_stream] <= seqs_q[msgIn_stream] + 32'd1;
        end
    end

endmodule

// File: tb/tb_packetizer.sv
// Directed table-driven bench for packetizer plus backpressure and
// mid-packet reset sequences.
module tb_packetizer;

    logic          clk;
    logic          reset_b;
    logic [0:295]  msgIn;
    logic [5:0]    msgIn_len;
    logic [4:0]    msgIn_stream;
    logic          msgIn_val;
    logic          msgIn_ready;
    logic [31:0]   dataOut;
    logic          dataOut_val;
    logic          dataOut_ready;
    logic          dataOut_last;
    logic          badLen;

    packetizer dut (
        .clk           (clk),
        .reset_b       (reset_b),
        .msgIn         (msgIn),
        .msgIn_len     (msgIn_len),
        .msgIn_stream  (msgIn_stream),
        .msgIn_val     (msgIn_val),
        .msgIn_ready   (msgIn_ready),
        .dataOut       (dataOut),
        .dataOut_val   (dataOut_val),
        .dataOut_ready (dataOut_ready),
        .dataOut_last  (dataOut_last),
        .badLen        (badLen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  s;
        logic [5:0]  l;
        logic [7:0]  base;
        logic        bad;
        logic [31:0] hdr;
        logic [31:0] seq;
        int          nw;
        logic [31:0] d0;
        logic [31:0] fin;
    } vec_t;

    int          checks;
    int          failures;
    logic [31:0] wbuf [0:15];
    logic        lbuf [0:15];
    int          n_got;
    int          nlast;
    int          gaps;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    // Payload byte k = base+k for all 37 slots, so bytes beyond L are nonzero on input.
    task automatic drive(input logic [4:0] s, input logic [5:0] l, input logic [7:0] base);
        logic [0:295] m;
        for (int k = 0; k < 37; k++) m[8*k +: 8] = base + 8'(k);
        msgIn        = m;
        msgIn_len    = l;
        msgIn_stream = s;
    endtask

    task automatic run_pkt(input logic [4:0] s, input logic [5:0] l, input logic [7:0] base,
                           input int stall_at, input int stall_n, input int abort_at);
        int st;
        int cyc;
        logic [31:0] held;
        n_got = 0; nlast = 0; gaps = 0; st = 0; held = '0;
        chk("idle_ready", {31'b0, msgIn_ready}, 32'd1);
        drive(s, l, base);
        msgIn_val = 1'b1;
        @(negedge clk);
        msgIn_val = 1'b0;
        chk("hdr_next_cycle", {31'b0, dataOut_val}, 32'd1);
        for (cyc = 0; cyc < 60; cyc++) begin
            if (dataOut_val) begin
                chk("ready_busy", {31'b0, msgIn_ready}, 32'd0);
                if (n_got == abort_at) begin
                    reset_b = 1'b0;
                    @(negedge clk);
                    return;
                end
                if (n_got == stall_at && st < stall_n) begin
                    if (st > 0) chk("stall_hold", dataOut, held);
                    held = dataOut;
                    dataOut_ready = 1'b0;
                    st++;
                end else begin
                    if (st > 0 && n_got == stall_at) chk("stall_release", dataOut, held);
                    dataOut_ready = 1'b1;
                    if (n_got < 16) begin
                        wbuf[n_got] = dataOut;
                        lbuf[n_got] = dataOut_last;
                    end
                    if (dataOut_last) nlast++;
                    n_got++;
                    if (dataOut_last) break;
                end
            end else begin
                gaps++;
            end
            @(negedge clk);
        end
        if (cyc >= 60) begin
            checks++;
            failures++;
            $display("FAIL pkt_timeout got=%0d words exp=last word within 60 cycles", n_got);
            dataOut_ready = 1'b1;
        end
        @(negedge clk);
        chk("post_val", {31'b0, dataOut_val}, 32'd0);
        chk("post_data_zero", dataOut, 32'd0);
        chk("post_last", {31'b0, dataOut_last}, 32'd0);
        chk("post_ready", {31'b0, msgIn_ready}, 32'd1);
    endtask

    task automatic check_pkt(input int id, input vec_t v);
        int lastix;
        logic [31:0] exp;
        int idx;
        chk($sformatf("v%0d_words", id), 32'(n_got), 32'(v.nw));
        chk($sformatf("v%0d_gaps", id), 32'(gaps), 32'd0);
        chk($sformatf("v%0d_hdr", id), wbuf[0], v.hdr);
        chk($sformatf("v%0d_seq", id), wbuf[1], v.seq);
        chk($sformatf("v%0d_d0", id), wbuf[2], v.d0);
        lastix = (n_got >= 1 && n_got <= 16) ? n_got - 1 : 0;
        chk($sformatf("v%0d_final", id), wbuf[lastix], v.fin);
        chk($sformatf("v%0d_nlast", id), 32'(nlast), 32'd1);
        chk($sformatf("v%0d_last_pos", id), {31'b0, lbuf[lastix]}, 32'd1);
        for (int i = 2; i < n_got && i < 16; i++) begin
            for (int b = 0; b < 4; b++) begin
                idx = 4*(i-2) + b;
                exp[31-8*b -: 8] = (idx < int'(v.l)) ? v.base + 8'(idx) : 8'h00;
            end
            chk($sformatf("v%0d_dw%0d", id, i-2), wbuf[i], exp);
        end
    endtask

    vec_t tv [11];
    vec_t vx;

    initial begin
        checks = 0; failures = 0;
        tv[0]  = '{5'd3,  6'd5,  8'h01, 1'b0, 32'h0D000003, 32'h00000000, 4,  32'h01020304, 32'h05000000};
        tv[1]  = '{5'd3,  6'd5,  8'h01, 1'b0, 32'h0D000003, 32'h01000000, 4,  32'h01020304, 32'h05000000};
        tv[2]  = '{5'd0,  6'd8,  8'h10, 1'b0, 32'h10000000, 32'h00000000, 4,  32'h10111213, 32'h14151617};
        tv[3]  = '{5'd31, 6'd1,  8'hAA, 1'b0, 32'h0900001F, 32'h00000000, 3,  32'hAA000000, 32'hAA000000};
        tv[4]  = '{5'd0,  6'd3,  8'h20, 1'b0, 32'h0B000000, 32'h01000000, 3,  32'h20212200, 32'h20212200};
        tv[5]  = '{5'd2,  6'd37, 8'h40, 1'b0, 32'h2D000002, 32'h00000000, 12, 32'h40414243, 32'h64000000};
        tv[6]  = '{5'd5,  6'd4,  8'h50, 1'b0, 32'h0C000005, 32'h00000000, 3,  32'h50515253, 32'h50515253};
        tv[7]  = '{5'd7,  6'd0,  8'h60, 1'b1, 32'h0,        32'h0,        0,  32'h0,        32'h0};
        tv[8]  = '{5'd7,  6'd38, 8'h60, 1'b1, 32'h0,        32'h0,        0,  32'h0,        32'h0};
        tv[9]  = '{5'd7,  6'd6,  8'h60, 1'b0, 32'h0E000007, 32'h00000000, 4,  32'h60616263, 32'h64650000};
        tv[10] = '{5'd3,  6'd9,  8'h01, 1'b0, 32'h11000003, 32'h02000000, 5,  32'h01020304, 32'h09000000};

        reset_b = 1'b0; msgIn = '0; msgIn_len = '0; msgIn_stream = '0;
        msgIn_val = 1'b0; dataOut_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'b0, msgIn_ready}, 32'd1);
        chk("rst_val", {31'b0, dataOut_val}, 32'd0);
        chk("rst_data", dataOut, 32'd0);
        chk("rst_last", {31'b0, dataOut_last}, 32'd0);
        chk("rst_badlen", {31'b0, badLen}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            if (tv[i].bad) begin
                drive(tv[i].s, tv[i].l, tv[i].base);
                msgIn_val = 1'b1;
                @(negedge clk);
                msgIn_val = 1'b0;
                chk($sformatf("v%0d_bad_pulse", i), {31'b0, badLen}, 32'd1);
                chk($sformatf("v%0d_bad_noval", i), {31'b0, dataOut_val}, 32'd0);
                chk($sformatf("v%0d_bad_ready", i), {31'b0, msgIn_ready}, 32'd1);
                @(negedge clk);
                chk($sformatf("v%0d_bad_end", i), {31'b0, badLen}, 32'd0);
                chk($sformatf("v%0d_bad_noval2", i), {31'b0, dataOut_val}, 32'd0);
            end else begin
                run_pkt(tv[i].s, tv[i].l, tv[i].base, -1, 0, -1);
                check_pkt(i, tv[i]);
            end
        end

        // Stall three cycles on the SEQ word; stream 3 is on its fourth packet.
        vx = '{5'd3, 6'd5, 8'h01, 1'b0, 32'h0D000003, 32'h03000000, 4, 32'h01020304, 32'h05000000};
        run_pkt(vx.s, vx.l, vx.base, 1, 3, -1);
        check_pkt(20, vx);

        // Reset while the second DATA word is presented.
        run_pkt(5'd3, 6'd9, 8'h01, -1, 0, 3);
        chk("abort_seq_word", wbuf[1], 32'h04000000);
        chk("abort_val", {31'b0, dataOut_val}, 32'd0);
        chk("abort_ready", {31'b0, msgIn_ready}, 32'd1);
        reset_b = 1'b1;
        @(negedge clk);

        vx = '{5'd3, 6'd5, 8'h01, 1'b0, 32'h0D000003, 32'h00000000, 4, 32'h01020304, 32'h05000000};
        run_pkt(vx.s, vx.l, vx.base, -1, 0, -1);
        check_pkt(21, vx);
        vx = '{5'd2, 6'd1, 8'h77, 1'b0, 32'h09000002, 32'h00000000, 3, 32'h77000000, 32'h77000000};
        run_pkt(vx.s, vx.l, vx.base, -1, 0, -1);
        check_pkt(22, vx);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
